// File: rtl/aes128_cipher_core.sv
// aes128_cipher_core
// Iterative AES-128 engine: encrypts or decrypts one 128-bit block per request.
// ROUNDS_PER_CYCLE AES rounds are chained combinationally per ROUND clock.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset, clears every register
//   start      request strobe, accepted only while idle
//   mode       0 = encrypt, 1 = decrypt (sampled with start)
//   key        128-bit cipher key (sampled with start)
//   din        plaintext / ciphertext (sampled with start)
//   dout       result block, held until the next done or reset
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse, dout has just been updated
//   dbg_state  current FSM state (0 IDLE, 1 EXPAND, 2 INIT, 3 ROUND)
//
// Handshake: start is a request strobe with no ready signal. It is taken on a
// rising edge only when the FSM is idle (busy = 0, which includes the done
// cycle); a start seen while busy is dropped, not queued. busy and done are
// never high together, and the edge that raises done also lowers busy.

module aes128_cipher_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic [127:0] dout,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
            $error("aes128_cipher_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
        end
    endgenerate

    localparam logic [3:0] RPC = 4'(ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_INIT   = 2'd2,
        S_ROUND  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic and byte substitution
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    // ------------------------------------------------------------------
    // Round primitives. Byte i of the state is bits [127-8i -: 8]; the
    // state is column-major, so byte i sits at row i%4, column i/4.
    // ------------------------------------------------------------------
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] sub_bytes_inverse(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox_inv(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows_inverse(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ gf_mul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ gf_mul(a3, 8'h03);
            o[103-32*c -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns_inverse(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // All 11 round keys; round key i occupies flat bits [128*i+127 : 128*i].
    function automatic logic [10:0][127:0] expansion_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [10:0][127:0] rk;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])}
                    ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 11; i++) rk[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
        return rk;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             state;
    logic [127:0]       key_q;
    logic [127:0]       din_q;
    logic               mode_q;
    logic [10:0][127:0] rk_q;
    logic [127:0]       st_q;
    logic [3:0]         r_q;

    // ------------------------------------------------------------------
    // Round chain: ROUNDS_PER_CYCLE rounds starting at counter r_q, going up
    // for encrypt and down for decrypt. Key indices are clamped to 10 so a
    // stray counter value can never address outside rk[0..10].
    // ------------------------------------------------------------------
    logic [127:0] round_out;
    logic [3:0]   idx;
    logic [3:0]   idx_c;
    logic         last_step;

    always_comb begin
        round_out = st_q;
        idx       = r_q;
        idx_c     = r_q;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            if (!mode_q) begin
                idx       = r_q + 4'(j);
                idx_c     = (idx > 4'd10) ? 4'd10 : idx;
                round_out = shift_rows(sub_bytes(round_out));
                if (idx != 4'd10) round_out = mix_columns(round_out);
                round_out = round_out ^ rk_q[idx_c];
            end else begin
                idx       = r_q - 4'(j);
                idx_c     = (idx > 4'd10) ? 4'd10 : idx;
                round_out = sub_bytes_inverse(shift_rows_inverse(round_out));
                round_out = round_out ^ rk_q[idx_c];
                if (idx != 4'd0) round_out = mix_columns_inverse(round_out);
            end
        end
    end

    // This ROUND cycle ends with round 10 (encrypt) or round 0 (decrypt).
    assign last_step = mode_q ? (r_q == RPC - 4'd1) : (r_q == 4'd11 - RPC);

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            key_q  <= '0;
            din_q  <= '0;
            mode_q <= 1'b0;
            rk_q   <= '0;
            st_q   <= '0;
            r_q    <= '0;
            dout   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_q  <= key;
                        din_q  <= din;
                        mode_q <= mode;
                        busy   <= 1'b1;
                        state  <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    rk_q  <= expansion_key(key_q);
                    state <= S_INIT;
                end
                S_INIT: begin
                    if (mode_q) begin
                        st_q <= din_q ^ rk_q[10];
                        r_q  <= 4'd9;
                    end else begin
                        st_q <= din_q ^ rk_q[0];
                        r_q  <= 4'd1;
                    end
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    if (last_step) begin
                        // Final round result goes straight to dout.
                        dout  <= round_out;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        r_q   <= '0;
                        state <= S_IDLE;
                    end else begin
                        st_q <= round_out;
                        r_q  <= mode_q ? (r_q - RPC) : (r_q + RPC);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes128_cipher_core.md
# aes128_cipher_core

Iterative AES-128 engine that performs either encryption or decryption of one 128-bit block per request, selected per operation by a mode input. It generalises the single-direction, one-step-per-state decryption controller: the number of rounds evaluated per clock is a parameter, and results are registered with a clean start/busy/done handshake. It sits between the I2C register bank and the key/state datapath primitives: `expansion_key`, `add_round_key`, `sub_bytes`, `sub_bytes_inverse`, `shift_rows`, `shift_rows_inverse`, `mix_columns` and `mix_columns_inverse`.

## Interface

**Parameters**

- `ROUNDS_PER_CYCLE`, default 1: AES rounds evaluated per clock.
  - Legal values: 1, 2, 5, 10.
  - Any other value is a elaboration error, raised via a generate-time check.

**Ports**

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-low. Asserting it (0) clears all state immediately.
- `start`, input, 1: request strobe, sampled on the rising edge while idle.
- `mode`, input, 1: 0 = encrypt, 1 = decrypt. Sampled together with `start`.
- `key`, input, 128: cipher key, sampled with `start`.
- `din`, input, 128: plaintext (encrypt) or ciphertext (decrypt), sampled with `start`.
- `dout`, output, 128: result block, valid from `done` until the next result overwrites it.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done` is asserted.
- `done`, output, 1: single-cycle pulse marking that `dout` has just been updated.

## Operation

**State machine:** IDLE → EXPAND → INIT → ROUND → IDLE.

- **IDLE**
  - `start` = 1 latches `key`, `din` and `mode` into internal registers and moves to EXPAND.
  - `start` = 0 stays in IDLE.
- **EXPAND**
  - Feeds the latched key to `expansion_key`.
  - Registers the 11 round keys: `rk[i]` = flat bits `[128*i+127 : 128*i]`.
  - Moves to INIT.
- **INIT**
  - Encrypt: `st <= din ^ rk[0]`, round counter `r <= 1`.
  - Decrypt: `st <= din ^ rk[10]`, round counter `r <= 9`.
  - Moves to ROUND.
- **ROUND**
  - Applies `ROUNDS_PER_CYCLE` chained rounds combinationally, then registers the result to `st`.
  - Encrypt round `r`: SubBytes → ShiftRows → MixColumns → AddRoundKey(`rk[r]`). MixColumns is skipped when `r` = 10. The counter then increments.
  - Decrypt round `r`: InvShiftRows → InvSubBytes → AddRoundKey(`rk[r]`) → InvMixColumns. InvMixColumns is skipped when `r` = 0. The counter then decrements.
  - The final round (encrypt `r` = 10, decrypt `r` = 0) is the last stage of the last ROUND cycle. It writes `dout` directly and pulses `done`, then returns to IDLE.
- **Round counter:** 4 bits. It never leaves 0..10, and round keys are indexed only within `rk[0..10]`.
- **Key handling:** the key is re-expanded on every request. A changed `key` between requests needs no extra action.
- **`start` while busy** (EXPAND, INIT, ROUND) is ignored. It is not queued, and `key`, `din` and `mode` changes during that time have no effect.
- **`start` in the `done` cycle:** the FSM is already IDLE, so it is accepted and a new operation begins.
- **Reset mid-operation** aborts immediately with no partial result visible:
  - FSM returns to IDLE.
  - `dout`, `busy`, `done`, `st`, `r` and all round keys clear to 0.

## Timing

**Reset values:** `dout` = 0, `busy` = 0, `done` = 0, FSM = IDLE.

Let edge E0 be the edge that samples `start` = 1 in IDLE.

- EXPAND at E1, INIT at E2.
- ROUND occupies edges E3 … E(2 + 10/`ROUNDS_PER_CYCLE`).
- `done` and the new `dout` are visible after edge E(2 + N), where N = 10/`ROUNDS_PER_CYCLE`.
- Latency by parameter: 12 cycles (R=1), 7 (R=2), 4 (R=5), 3 (R=10).

**`busy`:**
- Rises after E0.
- Falls in the same edge that raises `done`. `busy` and `done` are never high together.

**Throughput:** back-to-back `start` gives one result every N + 3 cycles.

**`dout` stability:** holds its value until the next `done`. Reset is the only other event that changes it.

## Test plan

- **FIPS-197 App. C.1 encrypt, R=1:** `key` = 000102030405060708090a0b0c0d0e0f, `din` = 00112233445566778899aabbccddeeff, `mode` = 0.
  - `dout` = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `done` pulses exactly 12 cycles after `start`.
  - `busy` is high for exactly 12 cycles (E1 through E12), then falls as `done` rises.
- **Decrypt of the same vector, every legal `ROUNDS_PER_CYCLE` (1, 2, 5, 10):** `din` = 69c4e0…c55a, `mode` = 1.
  - `dout` = 00112233445566778899aabbccddeeff.
  - Latency is 12 / 7 / 4 / 3 cycles respectively.
- **FIPS-197 App. B, back-to-back:** `key` = 2b7e151628aed2a6abf7158809cf4f3c, `din` = 3243f6a8885a308d313198a2e0370734, encrypt, then decrypt with `start` re-asserted in the `done` cycle.
  - `dout` = 3925841d02dc09fbdc118597196a0b32, then 3243f6…0734.
  - No idle cycle between the two operations.
- **Start while busy:** pulse `start` with a different `din`/`key`/`mode` at E3 and at E5 of an App. C.1 encrypt.
  - Exactly one `done`, with `dout` = 69c4e0…c55a.
  - No second operation starts.
- **Reset mid-operation:** assert `rst` = 0 asynchronously (between clock edges) at cycle 6 of an encrypt.
  - `busy`, `done` and `dout` go to 0 immediately.
  - No `done` appears afterwards.
  - After release, a fresh App. B encrypt produces 3925841d…0b32 with nominal latency.
